seg_scan_ctrl: RTL

//  Latched, time-multiplexed N-digit seven-segment display controller.
//  - Holds a nibble-per-digit display register, written whole or per digit.
//  - Scans the digits at a programmable rate and drives shared segment lines plus per-digit anodes.
//  - Sits between the CPU/datapath output latch and the board's common-anode display.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: glyph table,
// blank pattern and a width helper for the scan index and prescaler.
package seg_pkg;

   // Active-high {g,f,e,d,c,b,a}; letters A b C d E F for 10..15.
   localparam logic [6:0] GLYPH_TBL [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Never returns 0 so a single-digit build still gets a 1-bit index.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      if (w == 0) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-high seven-segment glyph.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = GLYPH_TBL[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Latched, time-multiplexed N-digit seven-segment controller with
// programmable scan rate, optional leading-zero blanking and output polarity.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1,
   parameter int LZB        = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  we,
   input  logic [DIGITS-1:0]     digit_we,
   output logic [4*DIGITS-1:0]   data_out,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  scan_tick
);

   localparam int IW = clog2(DIGITS);
   localparam int PW = clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic          POL      = (ACTIVE_LOW != 0);

   logic [4*DIGITS-1:0] disp_q;
   logic [DIGITS-1:0]   dpreg_q;
   logic [PW-1:0]       pre_q;
   logic [IW-1:0]       idx_q;
   logic                tick_q;

   logic [DIGITS-1:0]   blank;
   logic                zero_above;
   logic [3:0]          sel_nib;
   logic                sel_dp;
   logic                sel_blank;
   logic [DIGITS-1:0]   sel_an;
   logic [6:0]          sel_glyph;

   logic [DIGITS-1:0]   an_q;
   logic [6:0]          seg_q;
   logic                dp_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         disp_q  <= '0;
         dpreg_q <= '0;
      end else if (we) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (digit_we[i]) begin
               disp_q[4*i +: 4] <= data_in[4*i +: 4];
               dpreg_q[i]       <= dp_in[i];
            end
         end
      end
   end

   // tick_q rises together with the new index value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_q  <= '0;
         idx_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (en) begin
            if (pre_q == PRE_LAST) begin
               pre_q  <= '0;
               tick_q <= 1'b1;
               idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
               pre_q <= pre_q + 1'b1;
            end
         end
      end
   end

   // Digit i>0 blanks when it and every higher nibble are zero.
   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (disp_q[4*i +: 4] == 4'h0);
         blank[i]   = (LZB != 0) && zero_above;
      end
   end

   always_comb begin
      sel_nib   = '0;
      sel_dp    = 1'b0;
      sel_blank = 1'b0;
      sel_an    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            sel_nib   = disp_q[4*i +: 4];
            sel_dp    = dpreg_q[i];
            sel_blank = blank[i];
            sel_an[i] = 1'b1;
         end
      end
   end

   seg_hex_decode u_dec (
      .nibble (sel_nib),
      .glyph  (sel_glyph)
   );

   // Polarity is applied only here; everything upstream is active-high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_q  <= {DIGITS{POL}};
         seg_q <= {7{POL}};
         dp_q  <= POL;
      end else begin
         an_q  <= (en ? sel_an : '0) ^ {DIGITS{POL}};
         seg_q <= ((en && !sel_blank) ? sel_glyph : SEG_OFF) ^ {7{POL}};
         dp_q  <= (en && !sel_blank && sel_dp) ^ POL;
      end
   end

   assign data_out  = disp_q;
   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;
   assign scan_tick = tick_q;

endmodule
